// File: rtl/life_seed_loader.sv
// Seed loader for the 8x8 life array: writes one board pattern, one quadrant word per clock.
// Optional feature: define SEED_LFSR_EN to make pattern code 3 emit pseudo-random words.
module life_seed_loader #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [1:0]  i_pattern_sel,
  output logic [1:0]  o_pos,
  output logic [15:0] o_val,
  output logic        o_write_enb,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [1:0]  r_cnt;
  logic [1:0]  r_sel;
  logic [15:0] w_word;

  // State register, quadrant counter and latched pattern code
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_sel   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StWrite) begin
        r_cnt <= r_cnt + 2'd1;
      end else begin
        r_cnt <= 2'd0;
      end
      if (r_state == StIdle && i_load) begin
        r_sel <= i_pattern_sel;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_load) w_state_next = StWrite;
      StWrite: if (r_cnt == 2'd3) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

`ifdef SEED_LFSR_EN
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

  // Free-running in every state so the load instant adds entropy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr <= SeedEff;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end
`else
  logic w_unused_seed;
  assign w_unused_seed = ^LFSR_SEED;
`endif

  // Quadrant word for the current pattern and counter
  always_comb begin
    w_word = 16'h0000;
    unique case (r_sel)
      2'd0: w_word = 16'h0000;
      2'd1: w_word = (r_cnt == 2'd0) ? 16'h0742 : 16'h0000;
      2'd2: w_word = (r_cnt == 2'd3) ? 16'h0070 : 16'h0000;
      2'd3: begin
`ifdef SEED_LFSR_EN
        w_word = r_lfsr;
`else
        unique case (r_cnt)
          2'd0: w_word = 16'h8000;
          2'd1: w_word = 16'h1000;
          2'd2: w_word = 16'h0008;
          2'd3: w_word = 16'h0001;
          default: w_word = 16'h0000;
        endcase
`endif
      end
      default: w_word = 16'h0000;
    endcase
  end

  // Outputs depend only on registered state
  always_comb begin
    o_pos       = 2'd0;
    o_val       = 16'h0000;
    o_write_enb = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      StWrite: begin
        o_pos       = r_cnt;
        o_val       = w_word;
        o_write_enb = 1'b1;
        o_busy      = 1'b1;
      end
      StDone: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_life_seed_loader.sv
// Directed bench for life_seed_loader; expected words are hand-computed from the board presets.
// Random-pattern expectations apply when SEED_LFSR_EN is defined.
module tb_life_seed_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [1:0]  pos;
  logic [15:0] val;
  logic        write_enb;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  life_seed_loader #(.LFSR_SEED(16'hACE1)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_load        (load),
    .i_pattern_sel (pattern_sel),
    .o_pos         (pos),
    .o_val         (val),
    .o_write_enb   (write_enb),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".we"},   {31'd0, write_enb}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy},      32'd0);
    chk({tag, ".done"}, {31'd0, done},      32'd0);
    chk({tag, ".pos"},  {30'd0, pos},       32'd0);
    chk({tag, ".val"},  {16'd0, val},       32'd0);
  endtask

  // One load pulse, pattern_sel scrambled during WRITE, then 4 writes, done, idle
  task automatic run_seq(input string tag, input logic [1:0] sel, input logic [63:0] words);
    pattern_sel = sel;
    load = 1'b1;
    tick();
    load = 1'b0;
    pattern_sel = sel ^ 2'b11;
    for (int k = 0; k < 4; k++) begin
      chk({tag, ".we"},   {31'd0, write_enb}, 32'd1);
      chk({tag, ".busy"}, {31'd0, busy},      32'd1);
      chk({tag, ".done"}, {31'd0, done},      32'd0);
      chk({tag, ".pos"},  {30'd0, pos},       k);
      chk({tag, ".val"},  {16'd0, val},       {16'd0, words[k*16 +: 16]});
      tick();
    end
    chk({tag, ".c5done"}, {31'd0, done},      32'd1);
    chk({tag, ".c5we"},   {31'd0, write_enb}, 32'd0);
    chk({tag, ".c5busy"}, {31'd0, busy},      32'd1);
    tick();
    chk_idle({tag, ".c6"});
  endtask

  int n_we;
  int n_done;

  initial begin
    // Reset for 3 cycles, then idle outputs
    reset = 1'b1;
    tick(); tick(); tick();
    chk_idle("rst");
    reset = 1'b0;
    tick();
    chk_idle("idle0");
    tick();
    chk_idle("idle1");

    run_seq("glider", 2'd1, {16'h0000, 16'h0000, 16'h0000, 16'h0742});
    run_seq("blinker", 2'd2, {16'h0070, 16'h0000, 16'h0000, 16'h0000});

    // Code 3 loaded in the first cycle after reset release
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef SEED_LFSR_EN
    run_seq("random", 2'd3, {16'h1C4E, 16'h389C, 16'h7138, 16'hE270});
`else
    run_seq("centre", 2'd3, {16'h0001, 16'h0008, 16'h1000, 16'h8000});
`endif

    // Second load during WRITE pos2 is ignored
    n_we = 0;
    n_done = 0;
    pattern_sel = 2'd1;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (write_enb) n_we++;
      if (done) n_done++;
      load = (c == 2);
      tick();
    end
    load = 1'b0;
    chk("ign.writes", n_we, 32'd4);
    chk("ign.done", n_done, 32'd1);
    chk_idle("ign.end");

    // Reset during WRITE pos1
    pattern_sel = 2'd1;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("rw.pos1", {30'd0, pos}, 32'd1);
    reset = 1'b1;
    tick();
    chk_idle("rw.after");
    reset = 1'b0;
    tick();
    chk_idle("rw.after2");
    run_seq("clear", 2'd0, 64'd0);

    // Load and reset together: reset wins
    reset = 1'b1;
    load = 1'b1;
    pattern_sel = 2'd1;
    tick();
    chk_idle("rstload");
    reset = 1'b0;
    load = 1'b0;
    tick();
    chk_idle("rstload2");

    // Load held high: restart on the first IDLE cycle after DONE
    pattern_sel = 2'd2;
    load = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("hold.we", {31'd0, write_enb}, 32'd1);
      tick();
    end
    chk("hold.done", {31'd0, done}, 32'd1);
    tick();
    chk("hold.idle", {31'd0, busy}, 32'd0);
    tick();
    chk("hold.rewe", {31'd0, write_enb}, 32'd1);
    chk("hold.repos", {30'd0, pos}, 32'd0);
    load = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk_idle("hold.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
